// File: rtl/pipeline_pkg.sv
// Shared widths, WB control bit positions and the MEM/WB bundle layout
// for the 5-stage pipeline registers.
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int WB_W   = 2;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int MEM_WB_W = WB_W + 2 * DATA_W + REG_W;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
  } mem_wb_t;

  function automatic logic wb_regwrite(
    input logic [WB_W-1:0] wb
  );
    return wb[WB_REGWRITE];
  endfunction

  function automatic logic wb_memtoreg(
    input logic [WB_W-1:0] wb
  );
    return wb[WB_MEMTOREG];
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous reset, flush to zero (bubble)
// and stall (hold). Priority is reset > flush > stall > load.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Zero on reset or flush, otherwise load unless stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: packs the WB controls, load data, ALU result
// and destination register into one flop bank and unpacks it for WB.
module mem_wb #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int REG_W  = pipeline_pkg::REG_W,
  parameter int WB_W   = pipeline_pkg::WB_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [WB_W-1:0]   WB,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] AluResult,
  input  logic [REG_W-1:0]  WriteReg,
  output logic [WB_W-1:0]   WB_OUT,
  output logic [DATA_W-1:0] ReadData_OUT,
  output logic [DATA_W-1:0] AluResult_OUT,
  output logic [REG_W-1:0]  WriteReg_OUT
);

  localparam int BUS_W = WB_W + 2 * DATA_W + REG_W;

  logic [BUS_W-1:0] bus_d;
  logic [BUS_W-1:0] bus_q;

  assign bus_d = {WB, ReadData, AluResult, WriteReg};

  pipe_reg #(
    .WIDTH (BUS_W)
  ) u_reg (
    .clk   (Clk),
    .reset (Reset),
    .stall (Stall),
    .flush (Flush),
    .d     (bus_d),
    .q     (bus_q)
  );

  assign {WB_OUT, ReadData_OUT, AluResult_OUT, WriteReg_OUT} = bus_q;

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: directed vectors push hand-computed
// results, a monitor pops one per rising edge and compares.
module tb_mem_wb;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    bit          mid;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  wb;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  logic [1:0]  wb_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  write_reg_out;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;

  mem_wb dut (
    .Clk           (clk),
    .Reset         (reset),
    .Stall         (stall),
    .Flush         (flush),
    .WB            (wb),
    .ReadData      (read_data),
    .AluResult     (alu_result),
    .WriteReg      (write_reg),
    .WB_OUT        (wb_out),
    .ReadData_OUT  (read_data_out),
    .AluResult_OUT (alu_result_out),
    .WriteReg_OUT  (write_reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input exp_t e);
    checks++;
    if (wb_out !== e.wb || read_data_out !== e.rd ||
        alu_result_out !== e.alu || write_reg_out !== e.wr) begin
      errors++;
      $display("FAIL %s: got wb=%b rd=%h alu=%h wr=%0d, expected wb=%b rd=%h alu=%h wr=%0d",
               name, wb_out, read_data_out, alu_result_out, write_reg_out,
               e.wb, e.rd, e.alu, e.wr);
    end
  endtask

  // Monitor: one expectation per edge after the first vector
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp("edge", e);
        if (e.mid) begin
          #3;
          cmp("mid_cycle_hold", e);
        end
      end
    end
  end

  task automatic step(
    input bit          r,
    input bit          s,
    input bit          f,
    input logic [1:0]  w,
    input logic [31:0] rd,
    input logic [31:0] alu,
    input logic [4:0]  wr,
    input logic [1:0]  ew,
    input logic [31:0] erd,
    input logic [31:0] ealu,
    input logic [4:0]  ewr,
    input bit          glitch
  );
    exp_t e;
    @(negedge clk);
    reset      = r;
    stall      = s;
    flush      = f;
    wb         = w;
    read_data  = rd;
    alu_result = alu;
    write_reg  = wr;
    e.wb  = ew;
    e.rd  = erd;
    e.alu = ealu;
    e.wr  = ewr;
    e.mid = glitch;
    sb.push_back(e);
    tag++;
    if (glitch) begin
      @(posedge clk);
      #3;
      wb         = ~w;
      read_data  = ~rd;
      alu_result = ~alu;
      write_reg  = ~wr;
    end
  endtask

  task automatic load(
    input logic [1:0]  w,
    input logic [31:0] rd,
    input logic [31:0] alu,
    input logic [4:0]  wr,
    input bit          glitch
  );
    step(0, 0, 0, w, rd, alu, wr, w, rd, alu, wr, glitch);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    wb = '0;
    read_data = '0;
    alu_result = '0;
    write_reg = '0;

    // Reset for two edges with non-zero inputs present
    step(1, 0, 0, 2'b11, 32'hAAAA5555, 32'h12345678, 5'd9,
         2'b00, 0, 0, 0, 0);
    step(1, 0, 0, 2'b11, 32'hAAAA5555, 32'h12345678, 5'd9,
         2'b00, 0, 0, 0, 0);
    load(2'b00, 0, 0, 0, 0);

    // Sequential load, each value held 100 ns
    repeat (10) load(2'b01, 1, 1, 1, 0);
    repeat (10) load(2'b10, 2, 2, 2, 0);

    // Stall holds through several edges
    load(2'b11, 32'hDEADBEEF, 32'h10, 5'd31, 0);
    repeat (3)
      step(0, 1, 0, 2'b00, 32'h1, 32'h2, 5'd3,
           2'b11, 32'hDEADBEEF, 32'h10, 5'd31, 0);
    load(2'b00, 32'h1, 32'h2, 5'd3, 0);

    // Flush inserts a bubble
    load(2'b10, 32'h55, 32'h66, 5'd7, 0);
    step(0, 0, 1, 2'b10, 32'h55, 32'h66, 5'd7,
         2'b00, 0, 0, 0, 0);
    load(2'b10, 32'h55, 32'h66, 5'd7, 0);
    step(0, 1, 1, 2'b11, 32'h77, 32'h88, 5'd8,
         2'b00, 0, 0, 0, 0);

    // Reset beats stall mid-stream, then boundary values
    load(2'b11, 32'hCAFEF00D, 32'h44, 5'd12, 0);
    step(1, 1, 0, 2'b11, 32'h99, 32'h99, 5'd20,
         2'b00, 0, 0, 0, 0);
    load(2'b01, 32'hFFFFFFFF, 32'h80000000, 5'd1, 0);

    // Inputs toggled between edges must not reach the outputs
    load(2'b10, 32'h0F0F0F0F, 32'h7FFFFFFF, 5'd16, 1);
    load(2'b01, 32'h00000001, 32'hFFFFFFFE, 5'd30, 1);

    begin : drain
      int n;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      #5;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d pending, expected 0", sb.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
